// File: rtl/apb_fifo_mc_pkg.sv
// ============================================================================
// apb_fifo_mc_pkg : register map, field offsets and address decode helper
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_fifo_mc_pkg;

  localparam int MAX_NCH = 8;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_STATUS     = 8'h04;
  localparam logic [7:0] ADDR_IRQ_EN     = 8'h08;
  localparam logic [7:0] ADDR_THRESH     = 8'h0C;
  localparam logic [7:0] ADDR_WDATA_BASE = 8'h10;
  localparam logic [7:0] ADDR_LEVEL_BASE = 8'h30;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_LSB = 8;
  localparam int ST_EMPTY_LSB   = 0;
  localparam int ST_FULL_LSB    = 8;
  localparam int ST_OVF_LSB     = 16;
  localparam int ST_LVL_LSB     = 24;
  localparam int IE_LVL_LSB     = 0;
  localparam int IE_OVF_LSB     = 8;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_CTRL   = 3'd1,
    SEL_STATUS = 3'd2,
    SEL_IRQ_EN = 3'd3,
    SEL_THRESH = 3'd4,
    SEL_WDATA  = 3'd5,
    SEL_LEVEL  = 3'd6
  } reg_sel_e;

  // Channel-indexed windows cover MAX_NCH slots; range checks against NCH happen in the top.
  function automatic reg_sel_e decode_addr(input logic [7:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr[1:0] == 2'b00) begin
      if (addr == ADDR_CTRL)
        sel = SEL_CTRL;
      else if (addr == ADDR_STATUS)
        sel = SEL_STATUS;
      else if (addr == ADDR_IRQ_EN)
        sel = SEL_IRQ_EN;
      else if (addr == ADDR_THRESH)
        sel = SEL_THRESH;
      else if (addr >= ADDR_WDATA_BASE && addr < ADDR_WDATA_BASE + 8'(4 * MAX_NCH))
        sel = SEL_WDATA;
      else if (addr >= ADDR_LEVEL_BASE && addr < ADDR_LEVEL_BASE + 8'(4 * MAX_NCH))
        sel = SEL_LEVEL;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sc_chan.sv
// ============================================================================
// fifo_sc_chan : single-channel synchronous FIFO with flush and registered pop data
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_sc_chan #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = LW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [LW-1:0] wptr;
  logic [LW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Extra MSB on the pointers distinguishes full from empty when the indices match.
  assign full    = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + LW'(1);
      if (do_pop) begin
        rptr <= rptr + LW'(1);
        dout <= mem[rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/apb_fifo_mc.sv
// ============================================================================
// apb_fifo_mc : NCH independent FIFOs behind one APB slave, with status and irq
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_fifo_mc
  import apb_fifo_mc_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int NCH   = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NCH-1:0]    rd_en,
  output logic [NCH*DW-1:0] rd_data,
  output logic [NCH-1:0]    empty,
  output logic [NCH-1:0]    full,
  output logic              irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  reg_sel_e       sel;
  logic [7:0]     off;
  logic [2:0]     ch;
  logic           ch_ok;
  logic           err;
  logic           wr_ok;

  logic           en;
  logic [NCH-1:0] ie_lvl;
  logic [NCH-1:0] ie_ovf;
  logic [LW-1:0]  thresh;
  logic [NCH-1:0] ovf;
  logic [NCH-1:0] lvl_hit;

  logic [NCH-1:0] push;
  logic [NCH-1:0] flush;
  logic [NCH-1:0] ovf_set;
  logic [NCH-1:0] ovf_clr;
  logic [NCH-1:0] lvl_set;
  logic [NCH-1:0] lvl_clr;
  logic [LW-1:0]  level_pad [MAX_NCH];

  logic [7:0]     empty8;
  logic [7:0]     full8;
  logic [7:0]     ovf8;
  logic [7:0]     lvl8;
  logic [7:0]     ie_lvl8;
  logic [7:0]     ie_ovf8;

  assign PREADY = 1'b1;

  always_comb begin
    sel   = decode_addr(PADDR);
    off   = (sel == SEL_WDATA) ? (PADDR - ADDR_WDATA_BASE) : (PADDR - ADDR_LEVEL_BASE);
    ch    = off[4:2];
    ch_ok = (32'(ch) < 32'(NCH));
    case (sel)
      SEL_WDATA: err = !PWRITE || !ch_ok;
      SEL_LEVEL: err = PWRITE || !ch_ok;
      SEL_NONE:  err = 1'b1;
      default:   err = 1'b0;
    endcase
  end

  assign PSLVERR = PSEL && PENABLE && err;
  assign wr_ok   = PSEL && PENABLE && PWRITE && !err;
  assign flush   = (wr_ok && sel == SEL_CTRL)   ? PWDATA[CTRL_FLUSH_LSB +: NCH] : '0;
  assign ovf_clr = (wr_ok && sel == SEL_STATUS) ? PWDATA[ST_OVF_LSB +: NCH]     : '0;
  assign lvl_clr = (wr_ok && sel == SEL_STATUS) ? PWDATA[ST_LVL_LSB +: NCH]     : '0;

  for (genvar c = 0; c < MAX_NCH; c++) begin : g_slot
    if (c < NCH) begin : g_chan
      assign push[c]    = wr_ok && (sel == SEL_WDATA) && (ch == 3'(c)) && en;
      assign ovf_set[c] = push[c] && full[c];
      assign lvl_set[c] = (thresh != '0) && (level_pad[c] >= thresh);

      fifo_sc_chan #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .LW    (LW)
      ) u_chan (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (push[c]),
        .pop   (rd_en[c]),
        .flush (flush[c]),
        .din   (PWDATA[DW-1:0]),
        .dout  (rd_data[c*DW +: DW]),
        .full  (full[c]),
        .empty (empty[c]),
        .level (level_pad[c])
      );
    end else begin : g_pad
      assign level_pad[c] = '0;
    end
  end

  // Channels beyond NCH read back as zero in every per-channel field.
  always_comb begin
    empty8  = '0;
    full8   = '0;
    ovf8    = '0;
    lvl8    = '0;
    ie_lvl8 = '0;
    ie_ovf8 = '0;
    empty8[NCH-1:0]  = empty;
    full8[NCH-1:0]   = full;
    ovf8[NCH-1:0]    = ovf;
    lvl8[NCH-1:0]    = lvl_hit;
    ie_lvl8[NCH-1:0] = ie_lvl;
    ie_ovf8[NCH-1:0] = ie_ovf;
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && !err) begin
      case (sel)
        SEL_CTRL:   PRDATA[CTRL_EN_BIT] = en;
        SEL_STATUS: begin
          PRDATA[ST_EMPTY_LSB +: 8] = empty8;
          PRDATA[ST_FULL_LSB +: 8]  = full8;
          PRDATA[ST_OVF_LSB +: 8]   = ovf8;
          PRDATA[ST_LVL_LSB +: 8]   = lvl8;
        end
        SEL_IRQ_EN: begin
          PRDATA[IE_LVL_LSB +: 8] = ie_lvl8;
          PRDATA[IE_OVF_LSB +: 8] = ie_ovf8;
        end
        SEL_THRESH: PRDATA[LW-1:0] = thresh;
        SEL_LEVEL:  PRDATA[LW-1:0] = level_pad[ch];
        default:    PRDATA = '0;
      endcase
    end
  end

  // Sticky flags: a same-cycle set overrides the write-1-to-clear.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      en      <= 1'b0;
      ie_lvl  <= '0;
      ie_ovf  <= '0;
      thresh  <= '0;
      ovf     <= '0;
      lvl_hit <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_ok && sel == SEL_CTRL)
        en <= PWDATA[CTRL_EN_BIT];
      if (wr_ok && sel == SEL_IRQ_EN) begin
        ie_lvl <= PWDATA[IE_LVL_LSB +: NCH];
        ie_ovf <= PWDATA[IE_OVF_LSB +: NCH];
      end
      if (wr_ok && sel == SEL_THRESH)
        thresh <= PWDATA[LW-1:0];
      ovf     <= (ovf & ~ovf_clr) | ovf_set;
      lvl_hit <= (lvl_hit & ~lvl_clr) | lvl_set;
      irq     <= (|(lvl_hit & ie_lvl)) | (|(ovf & ie_ovf));
    end
  end

  logic unused_bits;
  assign unused_bits = ^{PWDATA, off};

endmodule

`default_nettype wire

// File: tb/tb_apb_fifo_mc.sv
// ============================================================================
// tb_apb_fifo_mc : directed + randomized bench against a queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_fifo_mc;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int NCH   = 2;

  logic              PCLK    = 1'b0;
  logic              PRESETn = 1'b0;
  logic              PSEL    = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE  = 1'b0;
  logic [7:0]        PADDR   = '0;
  logic [31:0]       PWDATA  = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [NCH-1:0]    rd_en   = '0;
  logic [NCH*DW-1:0] rd_data;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    full;
  logic              irq;

  apb_fifo_mc #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]     mq [NCH][$];
  logic           m_en;
  logic [15:0]    m_ie;
  logic [3:0]     m_th;
  logic [NCH-1:0] m_ovf;
  logic [NCH-1:0] m_lvl;
  logic           m_irq;
  logic [7:0]     m_rd [NCH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_rd[c] = '0;
    end
    m_en = 0; m_ie = '0; m_th = '0; m_ovf = '0; m_lvl = '0; m_irq = 0;
  endtask

  function automatic bit m_err(input logic [7:0] a, input logic w);
    int unsigned chn;
    if (a[1:0] != 2'b00) return 1;
    if (a <= 8'h0C) return 0;
    if (a >= 8'h10 && a < 8'h30) begin
      chn = (a - 8'h10) / 4;
      return !w || chn >= NCH;
    end
    if (a >= 8'h30 && a < 8'h50) begin
      chn = (a - 8'h30) / 4;
      return w || chn >= NCH;
    end
    return 1;
  endfunction

  function automatic logic [31:0] m_prdata(input logic s, input logic w, input logic [7:0] a);
    logic [31:0] st;
    if (!s || w || m_err(a, 1'b0)) return '0;
    case (a)
      8'h00: return {31'd0, m_en};
      8'h04: begin
        st = '0;
        for (int c = 0; c < NCH; c++) begin
          st[c]      = (mq[c].size() == 0);
          st[8 + c]  = (mq[c].size() == DEPTH);
          st[16 + c] = m_ovf[c];
          st[24 + c] = m_lvl[c];
        end
        return st;
      end
      8'h08:   return {16'd0, m_ie & 16'h0303};
      8'h0C:   return {28'd0, m_th};
      default: return 32'(mq[int'((a - 8'h30) / 4)].size());
    endcase
  endfunction

  // Applies one clock edge worth of spec behaviour, all decisions on pre-edge state.
  task automatic model_edge(input logic s, input logic p, input logic w, input logic [7:0] a,
                            input logic [31:0] d, input logic [NCH-1:0] re);
    bit wr, nirq, was_full, was_empty, pushreq;
    logic [NCH-1:0] ovf_set, lvl_set;
    wr   = s && p && w && !m_err(a, w);
    nirq = (|(m_lvl & m_ie[NCH-1:0])) || (|(m_ovf & m_ie[8 +: NCH]));
    ovf_set = '0;
    for (int c = 0; c < NCH; c++) begin
      lvl_set[c] = (m_th != 0) && (mq[c].size() >= int'(m_th));
      was_full   = (mq[c].size() == DEPTH);
      was_empty  = (mq[c].size() == 0);
      pushreq    = wr && (a == 8'(16 + 4 * c)) && m_en;
      if (wr && a == 8'h00 && d[8 + c]) begin
        mq[c].delete();
      end else begin
        if (re[c] && !was_empty) m_rd[c] = mq[c].pop_front();
        if (pushreq) begin
          if (was_full) ovf_set[c] = 1'b1;
          else mq[c].push_back(d[7:0]);
        end
      end
    end
    if (wr && a == 8'h04) begin
      m_ovf = m_ovf & ~d[16 +: NCH];
      m_lvl = m_lvl & ~d[24 +: NCH];
    end
    m_ovf = m_ovf | ovf_set;
    m_lvl = m_lvl | lvl_set;
    if (wr && a == 8'h00) m_en = d[0];
    if (wr && a == 8'h08) m_ie = d[15:0];
    if (wr && a == 8'h0C) m_th = d[3:0];
    m_irq = nirq;
  endtask

  task automatic post_check();
    logic [NCH-1:0] e, f;
    for (int c = 0; c < NCH; c++) begin
      e[c] = (mq[c].size() == 0);
      f[c] = (mq[c].size() == DEPTH);
    end
    check_val("rd_data", 32'(rd_data), 32'({m_rd[1], m_rd[0]}));
    check_val("empty", 32'(empty), 32'(e));
    check_val("full", 32'(full), 32'(f));
    check_val("irq", 32'(irq), 32'(m_irq));
  endtask

  // One clock: drive, check comb APB outputs at negedge, advance model, check registered outputs.
  task automatic cycle(input logic s, input logic p, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [NCH-1:0] re,
                       output logic [31:0] prd, output logic slv);
    PSEL = s; PENABLE = p; PWRITE = w; PADDR = a; PWDATA = d; rd_en = re;
    @(negedge PCLK);
    prd = PRDATA;
    slv = PSLVERR;
    check_val("prdata", PRDATA, m_prdata(s, w, a));
    check_val("pslverr", 32'(PSLVERR), 32'(s && p && m_err(a, w)));
    @(posedge PCLK);
    model_edge(s, p, w, a, d, re);
    #1;
    post_check();
  endtask

  task automatic idle(input logic [NCH-1:0] re);
    logic [31:0] prd;
    logic slv;
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, re, prd, slv);
  endtask

  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [NCH-1:0] re, output logic [31:0] prd, output logic slv);
    cycle(1'b1, 1'b0, w, a, d, '0, prd, slv);
    cycle(1'b1, 1'b1, w, a, d, re, prd, slv);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] prd;
    logic slv;
    apb(1'b1, a, d, '0, prd, slv);
  endtask

  task automatic do_reset();
    PRESETn = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
    PADDR = 8'h10; PWDATA = 32'h5A; rd_en = '1;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rd_en = '0;
    model_reset();
    post_check();
  endtask

  logic [31:0] prd;
  logic        slv;
  logic [7:0]  held;

  initial begin
    model_reset();
    do_reset();
    check_val("reset_empty", 32'(empty), 32'h3);
    check_val("pready", 32'(PREADY), 32'h1);

    // Ordering on channel 0
    wr(8'h00, 32'h1);
    wr(8'h10, 32'h11); wr(8'h10, 32'h22); wr(8'h10, 32'h33);
    idle(2'b01); check_val("order0", 32'(rd_data[7:0]), 32'h11);
    idle(2'b01); check_val("order1", 32'(rd_data[7:0]), 32'h22);
    idle(2'b01); check_val("order2", 32'(rd_data[7:0]), 32'h33);
    apb(1'b0, 8'h30, 32'h0, '0, prd, slv);
    check_val("level0_drained", prd, 32'h0);
    check_val("empty0", 32'(empty[0]), 32'h1);

    // Overflow on channel 1
    for (int i = 1; i <= 9; i++) begin
      wr(8'h14, 32'(i));
      if (i == 8) check_val("full1", 32'(full[1]), 32'h1);
    end
    apb(1'b0, 8'h04, 32'h0, '0, prd, slv);
    check_val("ovf1_set", 32'(prd[17]), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      idle(2'b10);
      check_val("ovf_pop", 32'(rd_data[15:8]), 32'(i));
    end
    wr(8'h04, 32'h0002_0000);
    apb(1'b0, 8'h04, 32'h0, '0, prd, slv);
    check_val("ovf1_clr", 32'(prd[17]), 32'h0);

    // Threshold interrupt
    wr(8'h0C, 32'h4);
    wr(8'h08, 32'h1);
    for (int i = 0; i < 4; i++) wr(8'h10, 32'(8'hA0 + i));
    apb(1'b0, 8'h04, 32'h0, '0, prd, slv);
    check_val("lvl_hit0", 32'(prd[24]), 32'h1);
    idle('0);
    check_val("irq_hi", 32'(irq), 32'h1);
    idle(2'b01);
    wr(8'h04, 32'h0100_0000);
    idle('0); idle('0);
    check_val("irq_lo", 32'(irq), 32'h0);
    wr(8'h08, 32'h0);
    wr(8'h0C, 32'h0);

    // Flush with concurrent pop, then push+pop at level 3
    wr(8'h00, 32'h0101);
    for (int i = 0; i < 5; i++) wr(8'h10, 32'(8'h50 + i));
    held = rd_data[7:0];
    apb(1'b1, 8'h00, 32'h0101, 2'b01, prd, slv);
    check_val("flush_rd_hold", 32'(rd_data[7:0]), 32'(held));
    check_val("flush_empty", 32'(empty[0]), 32'h1);
    apb(1'b0, 8'h30, 32'h0, '0, prd, slv);
    check_val("flush_level", prd, 32'h0);
    for (int i = 0; i < 3; i++) wr(8'h10, 32'(8'h60 + i));
    apb(1'b1, 8'h10, 32'h63, 2'b01, prd, slv);
    apb(1'b0, 8'h30, 32'h0, '0, prd, slv);
    check_val("pushpop_level", prd, 32'h3);

    // Error responses and EN=0 drop
    apb(1'b0, 8'h10, 32'h0, '0, prd, slv);
    check_val("err_rd_wdata", 32'(slv), 32'h1);
    apb(1'b1, 8'h4C, 32'hFF, '0, prd, slv);
    check_val("err_wr_level", 32'(slv), 32'h1);
    apb(1'b1, 8'h18, 32'hFF, '0, prd, slv);
    check_val("err_wr_ch2", 32'(slv), 32'h1);
    wr(8'h00, 32'h0);
    apb(1'b1, 8'h10, 32'h77, '0, prd, slv);
    check_val("en0_noerr", 32'(slv), 32'h0);
    apb(1'b0, 8'h30, 32'h0, '0, prd, slv);
    check_val("en0_dropped", prd, 32'h3);

    // Reset mid-fill
    wr(8'h00, 32'h1);
    wr(8'h14, 32'h12);
    do_reset();
    check_val("rst_empty", 32'(empty), 32'h3);
    check_val("rst_rd_data", 32'(rd_data), 32'h0);
    apb(1'b0, 8'h04, 32'h0, '0, prd, slv);
    check_val("rst_status", prd, 32'h0000_0003);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int unsigned k;
      logic [NCH-1:0] re;
      k  = $urandom_range(0, 99);
      re = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      if (k < 40)
        apb(1'b1, 8'(8'h10 + 4 * $urandom_range(0, 1)), $urandom, re, prd, slv);
      else if (k < 50)
        apb(1'b0, 8'(8'h30 + 4 * $urandom_range(0, 1)), 32'h0, re, prd, slv);
      else if (k < 58)
        apb(1'b0, 8'h04, 32'h0, re, prd, slv);
      else if (k < 63)
        apb(1'b1, 8'h04, $urandom, re, prd, slv);
      else if (k < 68)
        apb(1'b1, 8'h00, {16'd0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                               7'd0, ($urandom_range(0, 3) != 0)}, re, prd, slv);
      else if (k < 72)
        apb(1'b1, 8'h0C, 32'($urandom_range(0, 9)), re, prd, slv);
      else if (k < 76)
        apb(1'b1, 8'h08, $urandom, re, prd, slv);
      else if (k < 80)
        apb(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom & 32'hFFFF_00FF,
            re, prd, slv);
      else
        idle(re);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_fifo_mc.md
Name: apb_fifo_mc

Overview:
- Single-clock, multi-channel APB-programmable FIFO.
- Successor to the async APB FIFO, generalised in data width, depth and channel count (NCH independent FIFOs behind one APB slave).
- Adds per-channel flush, occupancy readback, sticky overflow flags, a programmable level threshold and a single interrupt output.
- Sits between a CPU APB bus (push side) and NCH streaming consumers (pop side), all on PCLK.

Parameters:
- DW, 8, data width per entry, 1..32.
- DEPTH, 8, entries per channel, power of 2, 2..256.
- NCH, 2, channel count, 1..8.
- Derived: LW = $clog2(DEPTH)+1, the level/pointer width.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, synchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB direction.
- PADDR  in  8  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready, tied 1.
- PSLVERR  out  1  APB error.
- rd_en  in  NCH  per-channel pop request.
- rd_data  out  NCH*DW  per-channel pop data, channel c at [c*DW +: DW].
- empty  out  NCH  per-channel empty.
- full  out  NCH  per-channel full.
- irq  out  1  interrupt, level, registered.

Behaviour:
- Clock and reset: one clock, PCLK. PRESETn is synchronous and active-low.
- Reset values: all registers and flags 0; empty all 1; full 0; rd_data 0; PRDATA 0; PSLVERR 0; irq 0; THRESH 0; pointers 0.
- APB protocol:
  - Zero wait states.
  - Writes commit on the clock edge where PSEL&PENABLE&PWRITE.
  - PRDATA is combinational from address while PSEL&!PWRITE, and 0 otherwise.
- Register map:
  - 0x00 CTRL RW: [0] EN; [15:8] FLUSH, write-1, self-clearing, reads 0.
  - 0x04 STATUS: [7:0] EMPTY RO; [15:8] FULL RO; [23:16] OVF W1C; [31:24] LVL_HIT W1C.
  - 0x08 IRQ_EN RW: [7:0] LVL_HIT enable; [15:8] OVF enable.
  - 0x0C THRESH RW: [LW-1:0].
  - 0x10+4*c WDATA_c WO: [DW-1:0].
  - 0x30+4*c LEVEL_c RO: [LW-1:0].
  - Bits for channels >= NCH read 0.
- PSLVERR is asserted in the access phase, with no state change, on:
  - an unmapped address;
  - a write to a RO register;
  - a read of WDATA;
  - any access to channel c >= NCH.
- Push: a WDATA_c write with EN=1 and !full[c] stores PWDATA[DW-1:0] and increments level.
  - With EN=1 and full[c], the write is dropped and OVF[c] is set.
  - With EN=0, the write is dropped silently; PSLVERR stays 0.
- Pop:
  - rd_en[c]&!empty[c] increments the read pointer.
  - rd_data[c] is registered and valid the cycle after the pop; it holds its value otherwise.
  - rd_en on empty is ignored and has no side effects.
  - Pops are permitted while EN=0, so channels can drain.
- Simultaneous events:
  - full/empty are evaluated on pre-edge state.
  - Push+pop on a non-full, non-empty channel: level unchanged.
  - Push on full with simultaneous pop: push rejected, OVF set, level becomes DEPTH-1.
  - Pop on empty with simultaneous push: pop ignored, level becomes 1.
- Flush on channel c:
  - Pointers and level go to 0 and empty[c] is 1 the next cycle.
  - A same-cycle push or pop on that channel is discarded.
  - OVF and LVL_HIT are unaffected.
- Pointers: LW bits, natural wrap. full = (wptr^rptr)=={1,0...}; empty = (wptr==rptr); level = wptr-rptr, mod 2^LW.
- LVL_HIT[c] is set on any edge where THRESH!=0 and level_c >= THRESH.
  - When a set and a W1C occur in the same cycle, the set wins.
  - The bit re-asserts while the condition persists.
- irq <= |(LVL_HIT & IRQ_EN[7:0]) | |(OVF & IRQ_EN[15:8]), with one cycle latency.
- Reset mid-operation: the sync reset aborts any APB transfer, and all channels return to reset state at that edge.

Decomposition:
- Package apb_fifo_mc_pkg:
  - address constants ADDR_CTRL, ADDR_STATUS, ADDR_IRQ_EN, ADDR_THRESH, ADDR_WDATA_BASE, ADDR_LEVEL_BASE;
  - STATUS/CTRL field offsets;
  - MAX_NCH=8.
- Sub-module fifo_sc_chan: single-channel sync FIFO with ports push, pop, flush, din, dout, full, empty, level. It is instantiated NCH times by generate.
- The top holds the APB decode, the register file and the irq logic.

Test Plan (DW=8, DEPTH=8, NCH=2):
- Ordering:
  - Stimulus: CTRL=1; write WDATA_0 0x11,0x22,0x33; pulse rd_en[0] three times.
  - Response: rd_data[0] = 0x11,0x22,0x33, each one cycle after its pop; LEVEL_0 reads 0; empty[0]=1.
- Overflow:
  - Stimulus: 9 writes to WDATA_1 (0x01..0x09).
  - Response: full[1]=1 after the 8th write; the 9th is dropped; STATUS[17]=1; pops return 0x01..0x08.
  - Then: W1C 0x0002_0000 to STATUS. Response: OVF cleared.
- Threshold irq:
  - Stimulus: THRESH=4, IRQ_EN=0x01; 4 writes to channel 0.
  - Response: STATUS[24]=1 and irq=1 one cycle later.
  - Then: pop 1 and W1C. Response: irq drops.
- Flush/concurrency:
  - Stimulus: fill ch0 to 5; write CTRL=0x0101 while rd_en[0]=1.
  - Response: LEVEL_0=0 and empty[0]=1, with rd_data[0] unchanged.
  - Then: push+pop in the same cycle at level 3. Response: level stays 3.
- Errors/EN=0:
  - Stimulus: read 0x10, write 0x04C, write 0x18.
  - Response: PSLVERR=1 on each, no state change.
  - Then: write WDATA_0 with EN=0. Response: dropped, PSLVERR=0.
- Reset: PRESETn low for one edge mid-fill → all reset values restored, empty=2'b11.
